piso_bit_serializer: RTL and testbench

PISO_BIT_SERIALIZER -- requirements
Module: piso_bit_serializer

---
 rtl/piso_bit_serializer.sv | 121 ++++++++++++
 tb/tb_piso_bit_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer
//
// Parallel-in / serial-out bit serializer with a ready/valid load port and a
// per-bit consume strobe. A word accepted on the load handshake is shifted
// out one bit per cycle in which bit_en is high. On the last-bit cycle a new
// word may be accepted so that consecutive words stream with no gap.
//
// Parameters:
//   WIDTH      bits per loaded word (2..32)
//   MSB_FIRST  1: MSB shifted out first, 0: LSB shifted out first
//
// Ports:
//   clk         single clock, rising-edge
//   reset       synchronous active-high reset
//   load_valid  load_data is offered this cycle
//   load_ready  the block accepts load_data this cycle
//   load_data   parallel word to serialize
//   bit_en      downstream consumer takes one bit this cycle
//   ser_out     current serial bit (0 when idle)
//   ser_valid   ser_out carries a payload bit consumed this cycle
//   frame_done  one-cycle pulse when the last bit of a word is consumed
//   busy        a word is held and not fully shifted
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int            CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam int            OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             last_bit;
  logic             accept;

  // The last-bit cycle is the only point inside a word where a new load may
  // be taken; this is what allows zero-gap back-to-back words.
  assign last_bit   = (state == SHIFT) && bit_en && (cnt == LAST);
  assign load_ready = !reset && ((state == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;

  // A reset landing on the last-bit cycle discards the word, so no
  // completion pulse is reported for it.
  assign frame_done = last_bit && !reset;
  assign ser_valid  = (state == SHIFT) && bit_en;
  assign busy       = (state == SHIFT);
  assign ser_out    = (state == SHIFT) ? sreg[OUT_IDX] : 1'b0;

  // Next-state logic: load, shift or hold. The shift direction moves bits
  // toward the output end and fills with zeros behind them.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          sreg_n  = load_data;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (cnt == LAST) begin
            if (accept) begin
              state_n = SHIFT;
              sreg_n  = load_data;
              cnt_n   = '0;
            end else begin
              state_n = IDLE;
              sreg_n  = '0;
              cnt_n   = '0;
            end
          end else begin
            sreg_n = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                               : {1'b0, sreg[WIDTH-1:1]};
            cnt_n  = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        sreg_n  = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // State register; reset overrides any handshake or shift in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// tb_piso_bit_serializer
//
// Drives two serializer instances (MSB-first and LSB-first, WIDTH=8) from the
// same stimulus. A queue of pending bits per instance acts as the reference:
// accepting a word pushes its bits in output order, each consumed bit pops
// one. A hand-written table covers a complete single-word transfer, and
// short sequences cover LSB-first order, back-to-back streaming, stalls,
// mid-word reset and a load offered while busy.
module tb_piso_bit_serializer;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       bit_en;

  logic m_ready, m_out, m_valid, m_done, m_busy;
  logic l_ready, l_out, l_valid, l_done, l_busy;

  int nvec = 0;
  int nerr = 0;

  bit qm[$];
  bit ql[$];

  logic s_out, s_valid, s_done, s_busy, s_ready;

  int         seen_valid;
  int         done_at[$];
  logic [7:0] msb_word;
  logic [7:0] lsb_word;
  int         lsb_pos;

  typedef struct {
    logic       rst;
    logic       lv;
    logic [7:0] ld;
    logic       ben;
    logic       e_out;
    logic       e_valid;
    logic       e_done;
    logic       e_busy;
    logic       e_ready;
  } vec_t;

  vec_t tbl[11];

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (m_ready),
    .load_data  (load_data),
    .bit_en     (bit_en),
    .ser_out    (m_out),
    .ser_valid  (m_valid),
    .frame_done (m_done),
    .busy       (m_busy)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (l_ready),
    .load_data  (load_data),
    .bit_en     (bit_en),
    .ser_out    (l_out),
    .ser_valid  (l_valid),
    .frame_done (l_done),
    .busy       (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearSeq();
    seen_valid = 0;
    done_at.delete();
    msb_word = '0;
    lsb_word = '0;
    lsb_pos  = 0;
  endtask

  // Compares both instances against the pending-bit queues and records
  // observations used by the sequence-level checks.
  task automatic checkOutput(input logic r, input logic ben);
    logic e_busy, e_valid, e_done, e_ready, e_mout, e_lout;
    e_busy  = (qm.size() != 0);
    e_valid = e_busy && ben;
    e_done  = !r && ben && (qm.size() == 1);
    e_ready = !r && (qm.size() == 0 || (qm.size() == 1 && ben));
    e_mout  = e_busy ? qm[0] : 1'b0;
    e_lout  = e_busy ? ql[0] : 1'b0;

    cmp("msb ser_out",    m_out,   e_mout);
    cmp("msb ser_valid",  m_valid, e_valid);
    cmp("msb frame_done", m_done,  e_done);
    cmp("msb busy",       m_busy,  e_busy);
    cmp("msb load_ready", m_ready, e_ready);
    cmp("lsb ser_out",    l_out,   e_lout);
    cmp("lsb ser_valid",  l_valid, e_valid);
    cmp("lsb frame_done", l_done,  e_done);
    cmp("lsb busy",       l_busy,  e_busy);
    cmp("lsb load_ready", l_ready, e_ready);

    s_out   = m_out;
    s_valid = m_valid;
    s_done  = m_done;
    s_busy  = m_busy;
    s_ready = m_ready;

    if (m_valid === 1'b1) begin
      seen_valid++;
      msb_word = {msb_word[6:0], m_out};
    end
    if (m_done === 1'b1) done_at.push_back(seen_valid);
    if (l_valid === 1'b1 && lsb_pos < 8) begin
      lsb_word[lsb_pos] = l_out;
      lsb_pos++;
    end
  endtask

  // One clock cycle: drive inputs, check mid-cycle, advance the reference
  // queues exactly as the clock edge should, then step past the edge.
  task automatic applyStimulus(input logic r, input logic lv,
                               input logic [7:0] ld, input logic ben);
    logic acc;
    reset      = r;
    load_valid = lv;
    load_data  = ld;
    bit_en     = ben;
    @(negedge clk);
    checkOutput(r, ben);
    acc = lv && !r && (qm.size() == 0 || (qm.size() == 1 && ben));
    if (r) begin
      qm.delete();
      ql.delete();
    end else begin
      if (ben && qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < 8; i++) begin
          qm.push_back(ld[7-i]);
          ql.push_back(ld[i]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    bit_en     = 1'b0;
    @(posedge clk);
    #1;

    // Single MSB-first word 0xB0 with bit_en held high.
    clearSeq();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].lv, tbl[i].ld, tbl[i].ben);
      cmp($sformatf("tbl%0d ser_out", i),    s_out,   tbl[i].e_out);
      cmp($sformatf("tbl%0d ser_valid", i),  s_valid, tbl[i].e_valid);
      cmp($sformatf("tbl%0d frame_done", i), s_done,  tbl[i].e_done);
      cmp($sformatf("tbl%0d busy", i),       s_busy,  tbl[i].e_busy);
      cmp($sformatf("tbl%0d load_ready", i), s_ready, tbl[i].e_ready);
    end
    cmp("tbl msb word", msb_word, 8'hB0);

    // LSB-first order of 0x0D.
    clearSeq();
    applyStimulus(1'b0, 1'b1, 8'h0D, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    cmp("lsb word 0x0D", lsb_word, 8'h0D);
    cmp("lsb bit count", lsb_pos, 8);

    // Back-to-back 0xB0 then 0xBB with load_valid held.
    clearSeq();
    applyStimulus(1'b0, 1'b1, 8'hB0, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b1, 8'hBB, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    cmp("b2b valid cycles", seen_valid, 16);
    cmp("b2b done count", done_at.size(), 2);
    if (done_at.size() == 2) begin
      cmp("b2b first done", done_at[0], 8);
      cmp("b2b second done", done_at[1], 16);
    end
    cmp("b2b second word", msb_word, 8'hBB);

    // Stall for 3 cycles with the second bit (0) on the line.
    clearSeq();
    applyStimulus(1'b0, 1'b1, 8'hB0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      cmp($sformatf("stall%0d ser_out", i),   s_out,   1'b0);
      cmp($sformatf("stall%0d ser_valid", i), s_valid, 1'b0);
      cmp($sformatf("stall%0d busy", i),      s_busy,  1'b1);
    end
    repeat (7) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    cmp("stall word", msb_word, 8'hB0);
    cmp("stall valid cycles", seen_valid, 8);

    // Reset pulsed after four bits of 0xFF.
    clearSeq();
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    cmp("rst load_ready during reset", s_ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    cmp("rst ser_out after", s_out, 1'b0);
    cmp("rst busy after", s_busy, 1'b0);
    cmp("rst load_ready after", s_ready, 1'b1);
    cmp("rst frame_done count", done_at.size(), 0);

    // Load of 0x55 offered during the third bit of 0xB0 is ignored.
    clearSeq();
    applyStimulus(1'b0, 1'b1, 8'hB0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
    cmp("busy load_ready", s_ready, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    cmp("ignored load busy", s_busy, 1'b0);
    cmp("ignored load ready", s_ready, 1'b1);
    cmp("ignored load word", msb_word, 8'hB0);
    cmp("ignored load valid cycles", seen_valid, 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
